// File: rtl/mc_ctrl.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath controls. Optional counters under `MC_CTRL_PERF_EN`.
module mc_ctrl #(
    parameter logic [2:0] NONE_DEFAULT_ALU = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       extop,
    output logic       luiop,
    output logic [2:0] alu_op,
    output logic       alu_b_sel,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] pc_sel,
    output logic       illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    state_t state, next_state;

    logic is_r, is_addu, is_subu, is_nop, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_ralu, is_legal;

    // The all-zero word (sll $0,$0,0) is executed as an addu into $0.
    assign is_r     = (opcode == OP_RTYPE);
    assign is_addu  = is_r && (funct == FN_ADDU);
    assign is_subu  = is_r && (funct == FN_SUBU);
    assign is_nop   = is_r && (funct == FN_NOP);
    assign is_jr    = is_r && (funct == FN_JR);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_ralu  = is_addu || is_subu || is_nop;
    assign is_legal = is_ralu || is_jr || is_ori || is_lui || is_lw || is_sw
                    || is_beq || is_j || is_jal;

    logic [2:0] dec_alu_op;
    logic       dec_b_sel, dec_extop, dec_luiop;

    // ALU/ext configuration per instruction, shared by EXEC and held into WB.
    always_comb begin
        dec_alu_op = NONE_DEFAULT_ALU;
        dec_b_sel  = 1'b0;
        dec_extop  = 1'b0;
        dec_luiop  = 1'b0;
        if (is_subu || is_beq) begin
            dec_alu_op = 3'b001;
        end else if (is_ori) begin
            dec_alu_op = 3'b010;
        end
        if (is_ori || is_lui || is_lw || is_sw) begin
            dec_b_sel = 1'b1;
        end
        if (is_lw || is_sw || is_beq) begin
            dec_extop = 1'b1;
        end
        if (is_lui) begin
            dec_luiop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        extop      = 1'b0;
        luiop      = 1'b0;
        alu_op     = NONE_DEFAULT_ALU;
        alu_b_sel  = 1'b0;
        reg_dst    = 2'b00;
        wd_sel     = 2'b00;
        pc_sel     = 2'b00;
        illegal    = 1'b0;
        case (state)
            S_RST: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    next_state = S_EXEC;
                end else begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op     = dec_alu_op;
                alu_b_sel  = dec_b_sel;
                extop      = dec_extop;
                luiop      = dec_luiop;
                next_state = S_WB;
                if (is_lw || is_sw) begin
                    next_state = S_MEM;
                end else if (is_beq) begin
                    pc_we      = zero;
                    pc_sel     = 2'b01;
                    next_state = S_FETCH;
                end else if (is_j || is_jal) begin
                    pc_we      = 1'b1;
                    pc_sel     = 2'b10;
                    next_state = S_FETCH;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'b10;
                        wd_sel  = 2'b10;
                    end
                end else if (is_jr) begin
                    pc_we      = 1'b1;
                    pc_sel     = 2'b11;
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                extop     = 1'b1;
                alu_b_sel = 1'b1;
                if (mem_ack) begin
                    next_state = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                wd_sel     = is_lw ? 2'b01 : 2'b00;
                reg_dst    = is_ralu ? 2'b01 : 2'b00;
                alu_op     = dec_alu_op;
                alu_b_sel  = dec_b_sel;
                extop      = dec_extop;
                luiop      = dec_luiop;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_RST;
            end
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic instr_done;

    // Only genuine completions re-enter FETCH from EXEC/MEM/WB; illegal exits from DECODE.
    assign instr_done = (next_state == S_FETCH)
                     && ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (state != S_RST) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (instr_done) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: an instruction-level model predicts every cycle's
// control outputs; a monitor pops and compares them each cycle.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, pc_we, ir_we, reg_we, extop, luiop;
    logic [2:0] alu_op;
    logic       alu_b_sel;
    logic [1:0] reg_dst, wd_sel, pc_sel;
    logic       illegal;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .extop     (extop),
        .luiop     (luiop),
        .alu_op    (alu_op),
        .alu_b_sel (alu_b_sel),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .pc_sel    (pc_sel),
        .illegal   (illegal)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       extop;
        logic       luiop;
        logic [2:0] alu_op;
        logic       alu_b_sel;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic [1:0] pc_sel;
        logic       illegal;
    } outv_t;

    typedef enum int {
        K_ADDU, K_SUBU, K_NOP, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
    } kind_t;

    outv_t expQ[$];
    outv_t traceExp[$];
    int    traceAck[$];
    int    nChecks = 0;
    int    nFails = 0;
    bit    monEn = 1'b0;
    int    cycleNo = 0;
    int    mCycles = 0;
    int    mInstrs = 0;

    function automatic outv_t dutOut();
        outv_t v;
        v = {mem_req, mem_we, pc_we, ir_we, reg_we, extop, luiop, alu_op,
             alu_b_sel, reg_dst, wd_sel, pc_sel, illegal};
        return v;
    endfunction

    task automatic checkOutput(input string name, input outv_t act, input outv_t exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s @%0d: got %h, expected %h", name, cycleNo, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ack code per cycle: 0/1 drive that value, 2 means no request so drive noise.
    task automatic addCycle(input outv_t r, input int ack);
        traceExp.push_back(r);
        traceAck.push_back(ack);
    endtask

    // Instruction-level model: what each phase of an instruction must request.
    task automatic buildTrace(input kind_t k, input int d1, input int d2, input bit z);
        outv_t r;
        outv_t alu;
        traceExp.delete();
        traceAck.delete();
        r = '0;
        r.mem_req = 1'b1;
        repeat (d1) addCycle(r, 0);
        r.ir_we = 1'b1;
        r.pc_we = 1'b1;
        addCycle(r, 1);
        r = '0;
        if (k == K_ILL) begin
            r.illegal = 1'b1;
            addCycle(r, 2);
            return;
        end
        addCycle(r, 2);
        alu = '0;
        case (k)
            K_SUBU:      alu.alu_op = 3'b001;
            K_ORI:       begin alu.alu_op = 3'b010; alu.alu_b_sel = 1'b1; end
            K_LUI:       begin alu.alu_b_sel = 1'b1; alu.luiop = 1'b1; end
            K_LW, K_SW:  begin alu.alu_b_sel = 1'b1; alu.extop = 1'b1; end
            K_BEQ:       begin alu.alu_op = 3'b001; alu.extop = 1'b1; end
            default:     ;
        endcase
        r = alu;
        case (k)
            K_BEQ: begin r.pc_we = z; r.pc_sel = 2'b01; addCycle(r, 2); end
            K_J:   begin r.pc_we = 1'b1; r.pc_sel = 2'b10; addCycle(r, 2); end
            K_JR:  begin r.pc_we = 1'b1; r.pc_sel = 2'b11; addCycle(r, 2); end
            K_JAL: begin
                r.pc_we = 1'b1; r.pc_sel = 2'b10;
                r.reg_we = 1'b1; r.reg_dst = 2'b10; r.wd_sel = 2'b10;
                addCycle(r, 2);
            end
            K_LW, K_SW: begin
                addCycle(r, 2);
                r.mem_req = 1'b1;
                r.mem_we = (k == K_SW);
                repeat (d2) addCycle(r, 0);
                addCycle(r, 1);
                if (k == K_LW) begin
                    r = alu;
                    r.reg_we = 1'b1;
                    r.wd_sel = 2'b01;
                    addCycle(r, 2);
                end
            end
            default: begin
                addCycle(r, 2);
                r.reg_we = 1'b1;
                r.reg_dst = (k inside {K_ADDU, K_SUBU, K_NOP}) ? 2'b01 : 2'b00;
                addCycle(r, 2);
            end
        endcase
    endtask

    // Called at #1 after the edge that opens the instruction's first FETCH cycle.
    task automatic applyStimulus(input kind_t k, input logic [5:0] op, input logic [5:0] fn,
                                 input int d1, input int d2, input bit z);
        buildTrace(k, d1, d2, z);
`ifdef MC_CTRL_PERF_EN
        checkWord("cycle_cnt", cycle_cnt, 32'(mCycles));
        checkWord("instr_cnt", instr_cnt, 32'(mInstrs));
`endif
        foreach (traceExp[i]) expQ.push_back(traceExp[i]);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < traceAck.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            mem_ack = (traceAck[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(traceAck[i]);
        end
        mCycles += traceAck.size();
        if (k != K_ILL) mInstrs++;
        @(posedge clk);
        #1;
    endtask

    task automatic randomInstr();
        kind_t k;
        logic [5:0] op, fn;
        int sel;
        k  = kind_t'($urandom_range(0, 11));
        fn = 6'($urandom_range(0, 63));
        case (k)
            K_ADDU: begin op = 6'h00; fn = 6'h21; end
            K_SUBU: begin op = 6'h00; fn = 6'h23; end
            K_NOP:  begin op = 6'h00; fn = 6'h00; end
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            K_ORI:  op = 6'h0D;
            K_LUI:  op = 6'h0F;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            default: begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       op = 6'h3F;
                    1:       begin op = 6'h00; fn = 6'h22; end
                    2:       op = 6'h05;
                    default: begin op = 6'h00; fn = 6'h09; end
                endcase
            end
        endcase
        applyStimulus(k, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    always @(posedge clk) cycleNo++;

    // Monitor: each cycle the DUT presents a control word, which must match the queue head.
    always @(negedge clk) begin
        if (monEn) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL scoreboard_empty @%0d: got %h, expected none", cycleNo, dutOut());
            end else begin
                checkOutput("cycle", dutOut(), expQ.pop_front());
            end
        end
    end

    initial begin
        outv_t r;
        // Power-on reset with a spurious ack present.
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", dutOut(), '0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_state", dutOut(), '0);
        @(posedge clk);
        #1;
        monEn = 1'b1;

        applyStimulus(K_ADDU, 6'h00, 6'h21, 0, 0, 1'b0);
        applyStimulus(K_LW,   6'h23, 6'h15, 3, 3, 1'b0);
        applyStimulus(K_ORI,  6'h0D, 6'h3F, 0, 0, 1'b1);
        applyStimulus(K_LUI,  6'h0F, 6'h01, 1, 0, 1'b0);
        applyStimulus(K_SW,   6'h2B, 6'h00, 0, 2, 1'b0);
        applyStimulus(K_BEQ,  6'h04, 6'h10, 0, 0, 1'b0);
        applyStimulus(K_BEQ,  6'h04, 6'h10, 0, 0, 1'b1);
        applyStimulus(K_JAL,  6'h03, 6'h2A, 0, 0, 1'b0);
        applyStimulus(K_J,    6'h02, 6'h05, 2, 0, 1'b1);
        applyStimulus(K_JR,   6'h00, 6'h08, 0, 0, 1'b0);
        applyStimulus(K_NOP,  6'h00, 6'h00, 0, 0, 1'b0);
        applyStimulus(K_SUBU, 6'h00, 6'h23, 1, 0, 1'b1);
        applyStimulus(K_ILL,  6'h3F, 6'h3F, 0, 0, 1'b0);
        applyStimulus(K_ADDU, 6'h00, 6'h21, 0, 0, 1'b0);

        // Reset in the middle of a stalled FETCH with ack asserted.
        r = '0;
        r.mem_req = 1'b1;
        expQ.push_back(r);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        monEn = 1'b0;
        reset_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        checkOutput("async_reset", dutOut(), '0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_hold", dutOut(), '0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_state_ack_ignored", dutOut(), '0);
        @(posedge clk);
        #1;
        mCycles = 0;
        mInstrs = 0;
        monEn = 1'b1;

        repeat (120) randomInstr();

        monEn = 1'b0;
        checkWord("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
